// File: rtl/rst_sequencer.sv
// rst_sequencer: releases NUM_STAGES active-low domain resets in index order after a filtered PLL lock.
// Optional macro RST_SEQ_READY_EN adds the per-stage ready handshake, ready timeout and sticky err.
module rst_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int LOCK_FILT  = 8,
  parameter int DELAY      = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pll_locked,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] rstn_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int LW = $clog2(LOCK_FILT + 1);
  localparam int DW = $clog2(DELAY + 1);
  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FILT);
  localparam logic [DW-1:0] GAP_LAST = DW'(DELAY - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_STAGES - 1);

`ifdef RST_SEQ_READY_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_DONE
  } state_t;
`endif

  state_t                  state, state_nxt;
  logic [LW-1:0]           lock_cnt, lock_cnt_nxt;
  logic [DW-1:0]           gap_cnt, gap_cnt_nxt;
  logic [KW-1:0]           k, k_nxt;
  logic [KW-1:0]           k_inc;
  logic [NUM_STAGES-1:0]   rstn_out_nxt;
  logic                    busy_nxt, done_nxt;

`ifdef RST_SEQ_READY_EN
  logic [TW-1:0]           to_cnt, to_cnt_nxt;
  logic                    err_nxt;
`else
  logic                    unused_stage_ready;
  assign unused_stage_ready = ^stage_ready;
  assign err = 1'b0;
`endif

  assign k_inc = k + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      lock_cnt <= '0;
      gap_cnt  <= '0;
      k        <= '0;
      rstn_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef RST_SEQ_READY_EN
      to_cnt   <= '0;
      err      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      k        <= k_nxt;
      rstn_out <= rstn_out_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
`ifdef RST_SEQ_READY_EN
      to_cnt   <= to_cnt_nxt;
      err      <= err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    gap_cnt_nxt  = gap_cnt;
    k_nxt        = k;
    rstn_out_nxt = rstn_out;
    busy_nxt     = busy;
    done_nxt     = done;
`ifdef RST_SEQ_READY_EN
    to_cnt_nxt   = to_cnt;
    err_nxt      = err;
`endif

    // Lock loss outside IDLE overrides any ready sample or timeout on the same edge.
    if (state != S_IDLE && !pll_locked) begin
      state_nxt    = S_IDLE;
      lock_cnt_nxt = '0;
      gap_cnt_nxt  = '0;
      k_nxt        = '0;
      rstn_out_nxt = '0;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b0;
`ifdef RST_SEQ_READY_EN
      to_cnt_nxt   = '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!pll_locked) begin
            lock_cnt_nxt = '0;
          end else if (lock_cnt == LOCK_MAX) begin
            lock_cnt_nxt    = '0;
            k_nxt           = '0;
            rstn_out_nxt[0] = 1'b1;
            busy_nxt        = 1'b1;
            gap_cnt_nxt     = '0;
`ifdef RST_SEQ_READY_EN
            to_cnt_nxt      = '0;
            state_nxt       = S_WAIT;
`else
            state_nxt       = S_GAP;
`endif
          end else begin
            lock_cnt_nxt = lock_cnt + 1'b1;
          end
        end

`ifdef RST_SEQ_READY_EN
        S_WAIT: begin
          if (stage_ready[k]) begin
            gap_cnt_nxt = '0;
            state_nxt   = S_GAP;
          end else if (to_cnt == TO_LAST) begin
            err_nxt         = 1'b1;
            rstn_out_nxt[k] = 1'b0;
            busy_nxt        = 1'b0;
            state_nxt       = S_FAULT;
          end else begin
            to_cnt_nxt = to_cnt + 1'b1;
          end
        end

        S_FAULT: begin
          state_nxt = S_FAULT;
        end
`endif

        S_GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt_nxt = gap_cnt + 1'b1;
          end else if (k == K_LAST) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_DONE;
          end else begin
            k_nxt               = k_inc;
            rstn_out_nxt[k_inc] = 1'b1;
            gap_cnt_nxt         = '0;
`ifdef RST_SEQ_READY_EN
            to_cnt_nxt          = '0;
            state_nxt           = S_WAIT;
`else
            state_nxt           = S_GAP;
`endif
          end
        end

        S_DONE: begin
          state_nxt = S_DONE;
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed timing scenarios plus randomized lock/ready traffic,
// all checked against a timestamp-based reference model (honours RST_SEQ_READY_EN).
module tb_rst_sequencer;

  localparam int NS = 3;
  localparam int LF = 8;
  localparam int DL = 4;
  localparam int TO = 32;

`ifdef RST_SEQ_READY_EN
  localparam bit            READY_EN      = 1'b1;
  localparam int            NOM_R1        = 14;
  localparam int            NOM_R2        = 19;
  localparam int            NOM_DONE      = 24;
  localparam int            NOM_BUSY_LAST = 23;
  localparam int            LL_R1         = 30;
  localparam int            LL_R2         = 35;
  localparam int            LL_DONE       = 40;
  localparam logic [NS-1:0] TO_RSTN       = 3'b001;
  localparam logic          TO_ERR        = 1'b1;
`else
  localparam bit            READY_EN      = 1'b0;
  localparam int            NOM_R1        = 13;
  localparam int            NOM_R2        = 17;
  localparam int            NOM_DONE      = 21;
  localparam int            NOM_BUSY_LAST = 20;
  localparam int            LL_R1         = 29;
  localparam int            LL_R2         = 33;
  localparam int            LL_DONE       = 37;
  localparam logic [NS-1:0] TO_RSTN       = 3'b111;
  localparam logic          TO_ERR        = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pll_locked = 1'b0;
  logic [NS-1:0] stage_ready = '0;
  logic [NS-1:0] rstn_out;
  logic          busy;
  logic          done;
  logic          err;

  rst_sequencer #(
    .NUM_STAGES(NS),
    .LOCK_FILT (LF),
    .DELAY     (DL),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pll_locked (pll_locked),
    .stage_ready(stage_ready),
    .rstn_out   (rstn_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: remembers when the current stage was released / accepted, not FSM state.
  int m_run, m_stage, m_t_rel, m_t_rdy;
  bit m_active, m_fault, m_fin, m_err;

  int            last_rise [NS];
  int            done_rise, busy_first, busy_last;
  logic [NS-1:0] prev_rstn;
  logic          prev_done;

  function automatic logic [NS-1:0] exp_rstn();
    logic [NS-1:0] v;
    v = '0;
    if (m_active)
      for (int i = 0; i < NS; i++)
        if (i < m_stage || (i == m_stage && !m_fault)) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_stage = 0; m_t_rel = 0; m_t_rdy = -1;
    m_active = 1'b0; m_fault = 1'b0; m_fin = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input bit lk, input logic [NS-1:0] rdy);
    if (!m_active) begin
      if (!lk) m_run = 0;
      else if (m_run >= LF) begin
        m_active = 1'b1; m_stage = 0; m_t_rel = edge_n;
        m_t_rdy = READY_EN ? -1 : edge_n;
        m_run = 0; m_fault = 1'b0; m_fin = 1'b0;
      end else m_run++;
    end else if (!lk) begin
      m_active = 1'b0; m_run = 0; m_fault = 1'b0; m_fin = 1'b0;
    end else if (m_fault || m_fin) begin
      m_run = 0;
    end else if (m_t_rdy < 0) begin
      if (rdy[m_stage]) m_t_rdy = edge_n;
      else if (edge_n - m_t_rel >= TO) begin
        m_fault = 1'b1; m_err = 1'b1;
      end
    end else if (edge_n - m_t_rdy >= DL) begin
      if (m_stage == NS - 1) m_fin = 1'b1;
      else begin
        m_stage++; m_t_rel = edge_n;
        m_t_rdy = READY_EN ? -1 : edge_n;
      end
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".rstn_out"}, 32'(rstn_out), 32'(exp_rstn()));
    checkVal({tag, ".busy"}, 32'(busy), 32'(m_active && !m_fault && !m_fin));
    checkVal({tag, ".done"}, 32'(done), 32'(m_fin));
    checkVal({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  task automatic applyStimulus(input bit lk, input logic [NS-1:0] rdy, input string tag);
    pll_locked  = lk;
    stage_ready = rdy;
    @(posedge clk);
    edge_n++;
    model_edge(lk, rdy);
    #1;
    checkOutput(tag);
    for (int i = 0; i < NS; i++)
      if (rstn_out[i] && !prev_rstn[i]) last_rise[i] = edge_n;
    if (done && !prev_done) done_rise = edge_n;
    if (busy) begin
      if (busy_first < 0) busy_first = edge_n;
      busy_last = edge_n;
    end
    prev_rstn = rstn_out;
    prev_done = done;
  endtask

  // Pulses rstn between clock edges and expects every output low before any edge arrives.
  task automatic doReset(input string tag);
    #1;
    rstn = 1'b0;
    pll_locked = 1'b0;
    stage_ready = '0;
    #1;
    model_reset();
    checkVal({tag, ".rst_rstn_out"}, 32'(rstn_out), 32'd0);
    checkVal({tag, ".rst_busy"}, 32'(busy), 32'd0);
    checkVal({tag, ".rst_done"}, 32'(done), 32'd0);
    checkVal({tag, ".rst_err"}, 32'(err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    edge_n = 0;
    for (int i = 0; i < NS; i++) last_rise[i] = -1;
    done_rise = -1; busy_first = -1; busy_last = -1;
    prev_rstn = '0; prev_done = 1'b0;
  endtask

  logic [NS-1:0] ready_mask;
  logic [NS-1:0] msk;
  logic [NS-1:0] r;
  int            drop_pct;
  bit            rnd_rdy;
  bit            lk;

  initial begin
    $display("[TB] rst_sequencer bench, ready handshake %0s", READY_EN ? "enabled" : "disabled");
    ready_mask = READY_EN ? 3'b111 : 3'b000;

    doReset("init");

    for (int i = 1; i <= 30; i++) applyStimulus(1'b1, exp_rstn() & ready_mask, "nom");
    checkVal("nom.rise0", 32'(last_rise[0]), 32'd9);
    checkVal("nom.rise1", 32'(last_rise[1]), 32'(NOM_R1));
    checkVal("nom.rise2", 32'(last_rise[2]), 32'(NOM_R2));
    checkVal("nom.done_rise", 32'(done_rise), 32'(NOM_DONE));
    checkVal("nom.busy_first", 32'(busy_first), 32'd9);
    checkVal("nom.busy_last", 32'(busy_last), 32'(NOM_BUSY_LAST));

    doReset("glitch");
    for (int i = 1; i <= 20; i++) applyStimulus(i != 6, exp_rstn() & ready_mask, "glitch");
    checkVal("glitch.rise0", 32'(last_rise[0]), 32'd15);

    doReset("loss");
    for (int i = 1; i <= 50; i++) begin
      applyStimulus(i != 16, exp_rstn() & ready_mask, "loss");
      if (i == 16) begin
        checkVal("loss.e16_rstn_out", 32'(rstn_out), 32'd0);
        checkVal("loss.e16_busy", 32'(busy), 32'd0);
      end
    end
    checkVal("loss.relock_rise0", 32'(last_rise[0]), 32'd25);
    checkVal("loss.relock_rise1", 32'(last_rise[1]), 32'(LL_R1));
    checkVal("loss.relock_rise2", 32'(last_rise[2]), 32'(LL_R2));
    checkVal("loss.relock_done", 32'(done_rise), 32'(LL_DONE));
    applyStimulus(1'b0, exp_rstn() & ready_mask, "loss_after_done");
    checkVal("loss_after_done.done", 32'(done), 32'd0);
    checkVal("loss_after_done.rstn_out", 32'(rstn_out), 32'd0);

    doReset("timeout");
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1'b1, exp_rstn() & ready_mask & 3'b101, "timeout");
      if (i == 46 || i == 60) begin
        checkVal("timeout.err", 32'(err), 32'(TO_ERR));
        checkVal("timeout.rstn_out", 32'(rstn_out), 32'(TO_RSTN));
      end
    end

    doReset("async_mid");

    for (int seg = 0; seg < 40; seg++) begin
      drop_pct = $urandom_range(0, 6);
      msk      = NS'($urandom);
      rnd_rdy  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) doReset("rnd_rst");
      for (int i = 0; i < 60; i++) begin
        lk = ($urandom_range(0, 99) >= drop_pct);
        if (rnd_rdy) r = NS'($urandom) & NS'($urandom);
        else         r = exp_rstn() & msk;
        applyStimulus(lk, r, "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Multi-domain reset release sequencer. Sits directly downstream of the active-low reset filter: takes its synchronized reset as `rstn` and a PLL lock indication. It releases `NUM_STAGES` active-low domain resets one at a time, in index order. Between releases it applies a filtered-lock qualification, a per-stage ready handshake and inter-stage delays, and it falls back to full reset on loss of lock.

## Interface
- `NUM_STAGES`, default 4: number of sequenced reset outputs (1..16).
- `LOCK_FILT`, default 8: consecutive cycles `pll_locked` must be sampled high before the sequence starts (≥1).
- `DELAY`, default 16: cycles from a stage being accepted to the next release (≥1).
- `TIMEOUT`, default 1024: maximum cycles to wait for `stage_ready[k]` (≥2).
- `clk`, input, 1: clock.
- `rstn`, input, 1: reset; asynchronous, active-low (driven by the upstream reset filter output).
- `pll_locked`, input, 1: PLL lock; synchronous to `clk`.
- `stage_ready`, input, NUM_STAGES: stage k reports it is out of reset; synchronous to `clk`. Used only with `RST_SEQ_READY_EN`.
- `rstn_out`, output, NUM_STAGES: active-low reset for each domain; bit 0 is released first.
- `busy`, output, 1: sequence in progress.
- `done`, output, 1: all stages released and accepted.
- `err`, output, 1: sticky ready-timeout flag.

## Operation
- Reset values while `rstn`=0: `rstn_out`='0, `busy`=0, `done`=0, `err`=0, FSM=IDLE, all counters 0.
- All outputs are registered. No combinational path runs from inputs to outputs.
- **IDLE**: `lock_cnt` increments on each edge that samples `pll_locked`=1 and clears on 0. When `LOCK_FILT` consecutive high samples have been seen, the next high-sampling edge does three things: sets `rstn_out[0]`=1, sets `busy`=1 and enters WAIT (k=0).
- **WAIT**: `to_cnt` counts edges since `rstn_out[k]` rose.
  - If `stage_ready[k]` is sampled 1, enter GAP.
  - If `to_cnt` reaches `TIMEOUT` with ready still 0, enter FAULT.
- **GAP**: count `DELAY` edges. On the final edge, one of two things happens:
  - If k<NUM_STAGES-1: set `rstn_out[k+1]`=1, k←k+1, return to WAIT.
  - Otherwise: set `done`=1, `busy`=0, enter DONE.
- **DONE**: hold until lock loss or `rstn`.
- **FAULT**: on entry, set `err`=1, drive `rstn_out[k]` back to 0, set `busy`=0. Stages below k stay released. Stages k and above stay in reset.
- **Lock loss**: `pll_locked` sampled 0 in WAIT, GAP, DONE or FAULT causes the following on that edge:
  - `rstn_out`='0, `done`=0, `busy`=0;
  - FSM→IDLE, all counters cleared.
  - `err` is sticky and is cleared only by `rstn`.
- A lock loss on the same edge as a ready sample or timeout takes priority.
- Width rules: counter widths are `$clog2(param+1)`; `k` is `$clog2(NUM_STAGES)` bits (min 1). Counters saturate and never wrap.
- `rstn` assertion mid-sequence clears everything asynchronously. Restart requires a fresh lock qualification.

## Timing
- Edge numbering: edge n is the n-th rising edge after `rstn` deassertion.
- Lock-to-first-release: with `pll_locked` sampled high from edge s, `rstn_out[0]` rises at edge s+`LOCK_FILT`.
- Ready sampled high at edge E: `rstn_out[k+1]` (or `done`) rises at edge E+`DELAY`.
- Timeout: `rstn_out[k]` rises at edge R with no ready. `err` rises and `rstn_out[k]` falls at edge R+`TIMEOUT`.
- Lock loss: all outputs drop on the first edge sampling `pll_locked`=0. This is one cycle of latency.

## Configuration
- `RST_SEQ_READY_EN` defined: the ready handshake and timeout are present, as described above.
- `RST_SEQ_READY_EN` undefined:
  - `stage_ready` is ignored; WAIT and FAULT are removed; `err` is tied 0.
  - `rstn_out[k+1]` (or `done`) rises `DELAY` edges after `rstn_out[k]` rose.

## Test plan
All scenarios use NUM_STAGES=3, LOCK_FILT=8, DELAY=4, TIMEOUT=32 and `RST_SEQ_READY_EN` defined unless stated.
- **Nominal sequence.** Stimulus: `pll_locked`=1 from edge 1; `stage_ready` = `rstn_out` delayed one cycle. Required: `rstn_out[0]`↑@9, [1]↑@14, [2]↑@19, `done`↑@24; `busy`=1 over edges 9..23.
- **Lock glitch.** Stimulus: `pll_locked` high at edges 1-5, low at 6, high from 7. Required: `rstn_out[0]`↑@15.
- **Timeout.** Stimulus: as the nominal sequence, but `stage_ready[1]` is stuck 0. Required: at edge 46, `err`=1 and `rstn_out`=3'b001; the bench checks these stay stuck there.
- **Lock loss during and after sequence.** Stimulus: `pll_locked`→0 at edge 16, then →1 again. Required: at edge 16, `rstn_out`=0 and `busy`=0; after relock the full sequence re-runs from lock qualification. The bench repeats the lock drop after `done` and checks `done` clears.
- **Async reset mid-sequence.** Stimulus: `rstn`=0 between edges. Required: all outputs are 0 immediately without a clock edge; `err` is cleared.
- **Macro undefined.** Stimulus: `RST_SEQ_READY_EN` undefined, `stage_ready`=0. Required: `rstn_out[0]`↑@9, [1]↑@13, [2]↑@17, `done`↑@21, `err`=0 throughout.
